// File: rtl/pipe_pkg.sv
// Shared types and helpers for the generic pipeline stage chain.
// Counter width, bubble/flush zero payload and the effective-hold evaluation.
package pipe_pkg;

  localparam int unsigned PIPE_CNT_W     = 32;
  localparam int unsigned PIPE_MAX_DEPTH = 32;
  localparam int unsigned PIPE_MAX_W     = 1024;

  localparam logic [PIPE_MAX_W-1:0] PIPE_ZERO = '0;

  // Stall ripples from the last stage upward; with collapse an empty stage breaks it.
  // Bits above the real depth are zero-extended inputs, so they never hold.
  function automatic logic [PIPE_MAX_DEPTH-1:0] pipe_hold_eff(
    input logic [PIPE_MAX_DEPTH-1:0] hold,
    input logic [PIPE_MAX_DEPTH-1:0] valid,
    input logic                      collapse
  );
    logic [PIPE_MAX_DEPTH:0] h;
    h = '0;
    for (int i = int'(PIPE_MAX_DEPTH) - 1; i >= 0; i--) begin
      h[i] = (hold[i] | h[i+1]) & (valid[i] | ~collapse);
    end
    return h[PIPE_MAX_DEPTH-1:0];
  endfunction

endpackage

// File: rtl/pipe_stage_chain_reg.sv
// One pipeline stage register: flush, hold, bubble or load, in that priority.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         flush,
  input  logic         hold,
  input  logic         up_held,
  input  logic         load_valid,
  input  logic [W-1:0] load_data,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid <= 1'b0;
      data  <= W'(PIPE_ZERO);
    end else if (flush) begin
      valid <= 1'b0;
      data  <= W'(PIPE_ZERO);
    end else if (hold) begin
      valid <= valid;
      data  <= data;
    end else if (up_held) begin
      valid <= 1'b0;
      data  <= W'(PIPE_ZERO);
    end else begin
      valid <= load_valid;
      data  <= load_valid ? load_data : W'(PIPE_ZERO);
    end
  end

endmodule

// File: rtl/pipe_stage_chain.sv
// DEPTH-stage pipeline register chain with per-stage hold/flush and stall propagation.
// Define PIPE_STAGE_CHAIN_PERF_EN to build the bubble/flush saturating counters.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int unsigned W        = 32,
  parameter int unsigned DEPTH    = 4,
  parameter bit          COLLAPSE = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [W-1:0]          IN_DATA,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [DEPTH-1:0]      HOLD,
  input  logic [DEPTH-1:0]      FLUSH,
  output logic [DEPTH*W-1:0]    STAGE_DATA,
  output logic [DEPTH-1:0]      STAGE_VALID,
  output logic [DEPTH-1:0]      HOLD_EFF,
  output logic [PIPE_CNT_W-1:0] BUBBLE_CNT,
  output logic [PIPE_CNT_W-1:0] FLUSH_CNT
);

  logic [DEPTH-1:0] hold_eff;
  logic [W-1:0]     stage_data [DEPTH];

  // DEPTH must not exceed PIPE_MAX_DEPTH.
  assign hold_eff = DEPTH'(pipe_hold_eff(PIPE_MAX_DEPTH'(HOLD), PIPE_MAX_DEPTH'(STAGE_VALID), COLLAPSE));
  assign HOLD_EFF = hold_eff;
  assign IN_READY = ~hold_eff[0];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic         up_held;
    logic         ld_valid;
    logic [W-1:0] ld_data;

    if (i == 0) begin : g_head
      assign up_held  = 1'b0;
      assign ld_valid = IN_VALID;
      assign ld_data  = IN_DATA;
    end else begin : g_body
      assign up_held  = hold_eff[i-1];
      assign ld_valid = STAGE_VALID[i-1];
      assign ld_data  = stage_data[i-1];
    end

    pipe_stage_reg #(.W(W)) u_reg (
      .CLK        (CLK),
      .RST        (RST),
      .flush      (FLUSH[i]),
      .hold       (hold_eff[i]),
      .up_held    (up_held),
      .load_valid (ld_valid),
      .load_data  (ld_data),
      .valid      (STAGE_VALID[i]),
      .data       (stage_data[i])
    );

    assign STAGE_DATA[i*W +: W] = stage_data[i];
  end

`ifdef PIPE_STAGE_CHAIN_PERF_EN
  logic [DEPTH-1:0]      bubble_vec;
  logic                  bubble_any;
  logic                  flush_hit;
  logic [PIPE_CNT_W-1:0] bubble_cnt;
  logic [PIPE_CNT_W-1:0] flush_cnt;

  // A stage bubbles when it moves while its upstream neighbour is held.
  assign bubble_vec = ~FLUSH & ~hold_eff & {hold_eff[DEPTH-2:0], 1'b0};
  assign bubble_any = |bubble_vec;
  assign flush_hit  = |(FLUSH & STAGE_VALID);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (bubble_any && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + PIPE_CNT_W'(1);
      if (flush_hit && (flush_cnt != '1))   flush_cnt  <= flush_cnt + PIPE_CNT_W'(1);
    end
  end

  assign BUBBLE_CNT = bubble_cnt;
  assign FLUSH_CNT  = flush_cnt;
`else
  assign BUBBLE_CNT = '0;
  assign FLUSH_CNT  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: COLLAPSE=0 and COLLAPSE=1 instances share stimulus and
// are compared every cycle against a queue-of-slots model, plus directed literal checks.
module tb_pipe_stage_chain;
  localparam int unsigned W = 8;
  localparam int unsigned D = 4;
`ifdef PIPE_STAGE_CHAIN_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic [D-1:0] hold = '0;
  logic [D-1:0] flush = '0;

  logic         ir0, ir1;
  logic [31:0]  sd0, sd1;
  logic [3:0]   sv0, sv1, he0, he1;
  logic [31:0]  bc0, fc0, bc1, fc1;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pipe_stage_chain #(.W(W), .DEPTH(D), .COLLAPSE(1'b0)) dut0 (
    .CLK(CLK), .RST(RST), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(ir0),
    .HOLD(hold), .FLUSH(flush), .STAGE_DATA(sd0), .STAGE_VALID(sv0), .HOLD_EFF(he0),
    .BUBBLE_CNT(bc0), .FLUSH_CNT(fc0));

  pipe_stage_chain #(.W(W), .DEPTH(D), .COLLAPSE(1'b1)) dut1 (
    .CLK(CLK), .RST(RST), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(ir1),
    .HOLD(hold), .FLUSH(flush), .STAGE_DATA(sd1), .STAGE_VALID(sv1), .HOLD_EFF(he1),
    .BUBBLE_CNT(bc1), .FLUSH_CNT(fc1));

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, idx, $time, act, exp);
    end
  endtask

  // Model: slot arrays per instance (index 0 = COLLAPSE 0, 1 = COLLAPSE 1).
  logic [7:0]  md [2][4];
  logic        mv [2][4];
  int unsigned mbub [2];
  int unsigned mfl  [2];

  // A slot is stuck if it is told to hold or the slot after it is stuck,
  // except that under collapse an empty slot can always be refilled.
  function automatic logic [3:0] m_he(input int c, input logic [3:0] h);
    logic [3:0] r;
    logic       below;
    below = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      r[i]  = (h[i] || below) && (mv[c][i] || c == 0);
      below = r[i];
    end
    return r;
  endfunction

  always @(posedge CLK or posedge RST) begin
    logic [3:0] he;
    logic [7:0] od [4];
    logic       ov [4];
    logic       bub, fh;
    if (RST) begin
      for (int c = 0; c < 2; c++) begin
        for (int i = 0; i < 4; i++) begin md[c][i] = 8'h00; mv[c][i] = 1'b0; end
        mbub[c] = 0; mfl[c] = 0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        he = m_he(c, hold);
        bub = 1'b0; fh = 1'b0;
        for (int i = 0; i < 4; i++) begin od[i] = md[c][i]; ov[i] = mv[c][i]; end
        for (int i = 0; i < 4; i++) begin
          if (flush[i]) begin
            if (ov[i]) fh = 1'b1;
            mv[c][i] = 1'b0; md[c][i] = 8'h00;
          end else if (he[i]) begin
            mv[c][i] = ov[i]; md[c][i] = od[i];
          end else if (i > 0 && he[i-1]) begin
            bub = 1'b1;
            mv[c][i] = 1'b0; md[c][i] = 8'h00;
          end else if (i == 0) begin
            mv[c][i] = in_valid; md[c][i] = in_valid ? in_data : 8'h00;
          end else begin
            mv[c][i] = ov[i-1]; md[c][i] = od[i-1];
          end
        end
        if (bub && mbub[c] != 32'hFFFF_FFFF) mbub[c]++;
        if (fh && mfl[c] != 32'hFFFF_FFFF) mfl[c]++;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge CLK) begin
    logic [3:0]  he, sv, hed;
    logic [31:0] sd, bc, fc;
    logic        ir;
    if (!RST) begin
      for (int c = 0; c < 2; c++) begin
        he  = m_he(c, hold);
        sd  = (c == 0) ? sd0 : sd1;
        sv  = (c == 0) ? sv0 : sv1;
        hed = (c == 0) ? he0 : he1;
        ir  = (c == 0) ? ir0 : ir1;
        bc  = (c == 0) ? bc0 : bc1;
        fc  = (c == 0) ? fc0 : fc1;
        for (int i = 0; i < 4; i++) begin
          chk("stage_valid", c*4+i, sv[i], mv[c][i]);
          chk("stage_data", c*4+i, sd[i*8 +: 8], md[c][i]);
        end
        chk("hold_eff", c, hed, he);
        chk("in_ready", c, ir, !he[0]);
        chk("bubble_cnt", c, bc, PERF ? mbub[c] : 0);
        chk("flush_cnt", c, fc, PERF ? mfl[c] : 0);
      end
    end
  end

  task automatic drive(input logic [7:0] d, input logic v, input logic [3:0] h, input logic [3:0] f);
    in_data = d; in_valid = v; hold = h; flush = f;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    tick();
    chk("rst_valid", 0, sv0, 4'h0);
    chk("rst_data", 0, sd0, 32'h0);
    chk("rst_bcnt", 0, bc0, 32'h0);
    chk("rst_ready", 0, ir0, 1'b1);
    RST = 1'b0;

    // Streaming
    drive(8'h11, 1, 4'h0, 4'h0); tick();
    drive(8'h22, 1, 4'h0, 4'h0); tick();
    drive(8'h33, 1, 4'h0, 4'h0); tick();
    drive(8'h44, 1, 4'h0, 4'h0); #1 chk("stream_ready", 0, ir0, 1'b1); tick();
    chk("stream4", 0, sd0, 32'h1122_3344);
    chk("stream4_v", 0, sv0, 4'hF);
    drive(8'h55, 1, 4'h0, 4'h0); tick();
    chk("stream5", 0, sd0, 32'h2233_4455);

    // Load-use stall on stage 1
    drive(8'h66, 1, 4'b0010, 4'h0); #1 chk("lu_ready", 0, ir0, 1'b0); tick();
    chk("lu_data", 0, sd0, 32'h3300_4455);
    chk("lu_valid", 0, sv0, 4'b1011);
    chk("lu_bcnt", 0, bc0, PERF ? 32'd1 : 32'd0);
    drive(8'h66, 1, 4'h0, 4'h0); tick();
    drive(8'h77, 1, 4'h0, 4'h0); tick();

    // Branch flush of stages 0,1
    drive(8'h88, 1, 4'h0, 4'b0011); tick();
    chk("bf_data", 0, sd0, 32'h5566_0000);
    chk("bf_valid", 0, sv0, 4'b1100);
    chk("bf_fcnt", 0, fc0, PERF ? 32'd1 : 32'd0);
    drive(8'h99, 1, 4'h0, 4'h0); tick();
    drive(8'hAA, 1, 4'h0, 4'h0); tick();
    drive(8'hBB, 1, 4'h0, 4'h0); tick();
    drive(8'hCC, 1, 4'h0, 4'h0); tick();
    chk("refill", 0, sd0, 32'h99AA_BBCC);

    // Simultaneous hold and flush on stage 2
    drive(8'hDD, 1, 4'b0100, 4'b0100); #1 chk("fh_ready", 0, ir0, 1'b0); tick();
    chk("fh_data", 0, sd0, 32'h0000_BBCC);
    chk("fh_valid", 0, sv0, 4'b0011);
    chk("fh_bcnt", 0, bc0, PERF ? 32'd2 : 32'd0);
    chk("fh_fcnt", 0, fc0, PERF ? 32'd2 : 32'd0);
    drive(8'hDD, 1, 4'h0, 4'h0); tick();
    drive(8'hEE, 1, 4'h0, 4'h0); tick();
    drive(8'hFF, 1, 4'h0, 4'b0100); tick();
    chk("gap_data", 0, sd0, 32'hCC00_EEFF);

    // Held last stage with an empty stage 2: collapse versus no collapse
    drive(8'h12, 1, 4'b1000, 4'h0); #1;
    chk("col_ready0", 0, ir0, 1'b0);
    chk("col_ready1", 1, ir1, 1'b1);
    chk("col_he0", 0, he0, 4'b1111);
    chk("col_he1", 1, he1, 4'b1000);
    tick();
    chk("col_data0", 0, sd0, 32'hCC00_EEFF);
    chk("col_data1", 1, sd1, 32'hCCEE_FF12);
    chk("col_valid1", 1, sv1, 4'b1111);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive(8'($urandom), 1'($urandom), 4'($urandom) & 4'($urandom),
            4'($urandom) & 4'($urandom) & 4'($urandom));
      tick();
    end

    // Asynchronous reset between edges
    drive(8'h5A, 1, 4'h0, 4'h0);
    @(posedge CLK); #3 RST = 1'b1; #1;
    chk("arst_valid0", 0, sv0, 4'h0);
    chk("arst_data0", 0, sd0, 32'h0);
    chk("arst_valid1", 1, sv1, 4'h0);
    chk("arst_data1", 1, sd1, 32'h0);
    chk("arst_bcnt", 0, bc0, 32'h0);
    chk("arst_fcnt", 0, fc0, 32'h0);
    @(posedge CLK); #2 RST = 1'b0;
    for (int n = 0; n < 8; n++) begin
      drive(8'($urandom), 1'b1, 4'h0, 4'h0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
